buff_uart_bus_arbiter: RTL and testbench
========================================

Name: buff_uart_bus_arbiter

Overview:
Round-robin arbiter sharing the buffered UART's register bus between several requesters, e.g. a CPU port and a DMA/loopback engine. Each requester posts a single read or write to a register address, such as the UART rx address 3 or tx address 4. The arbiter grants one requester at a time and drives one bus transaction. It returns read data or a timeout error to the owning requester.

Parameters:
requesters, 2, number of requester ports (>=1)
width, 8, data width; matches the UART data width
address_width, 8, register address width
timeout_cycles, 256, maximum WAIT cycles before the transaction is aborted with an error (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  requesters  per-requester transaction request
req_write  in  requesters  1=write, 0=read
req_address  in  requesters*address_width  packed addresses; requester i occupies slice i
req_data  in  requesters*width  packed write data
req_accept  out  requesters  one-cycle pulse: request latched
resp_valid  out  requesters  one-cycle pulse: transaction finished
resp_data  out  width  read data; meaningful only with resp_valid
resp_error  out  1  timeout flag; meaningful only with resp_valid
bus_address  out  address_width  register address to the UART
bus_read_enable  out  1  one-cycle read strobe
bus_write_enable  out  1  one-cycle write strobe
bus_wdata  out  width  write data
bus_rdata  in  width  read data, sampled on bus_ack
bus_ack  in  1  slave completion
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (reset).
- Reset: state=IDLE, rr_ptr=0, counter=0, owner=0.
  - All outputs 0: req_accept, resp_valid, resp_data, resp_error, bus_*, busy.
  - Reset asserted mid-transaction aborts it: no resp_valid is issued, and strobes are low from the cycle after the reset edge.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set index scanning rr_ptr, rr_ptr+1, ... with wrap modulo requesters.
  - At that edge, latch owner, write, address and data from the owner's slices, then go to ISSUE.
  - Requesters hold req_valid and their fields stable until req_accept is seen.
- ISSUE (exactly 1 cycle):
  - req_accept[owner]=1.
  - bus_address and bus_wdata are driven from the latch.
  - Exactly one of bus_read_enable or bus_write_enable is 1.
  - counter cleared.
  - If bus_ack=1 in this cycle (zero-wait slave), go to RESP. Otherwise go to WAIT.
- WAIT:
  - Strobes are 0; bus_address and bus_wdata are held.
  - On bus_ack: capture bus_rdata for reads (0 for writes), error=0, go to RESP.
  - Otherwise counter increments. When counter reaches timeout_cycles-1 without ack: error=1, data=0, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP (exactly 1 cycle):
  - resp_valid[owner]=1, with resp_data and resp_error.
  - rr_ptr <= (owner+1) mod requesters.
  - Next state IDLE.
- resp_data and resp_error hold their last values outside RESP.
- bus_ack in IDLE or RESP is ignored.
- Requester deasserts req_valid after the grant edge: the transaction still completes normally.
- Minimum service time:
  - Grant edge to resp_valid is 2 cycles (ISSUE, RESP).
  - Back-to-back transactions take 3 cycles each (IDLE, ISSUE, RESP).
- Fairness: a continuously requesting port waits at most requesters-1 transactions.
- requesters=1: rr_ptr is constant 0.
- Pointer wrap: owner=requesters-1 gives rr_ptr=0.

Test Plan:
- Reset, then requester 0 writes data 0x0A to address 4 with bus_ack in the ISSUE cycle -> bus_write_enable 1 cycle, bus_address=4, bus_wdata=0x0A; req_accept[0] in ISSUE; resp_valid[0] next cycle, resp_error=0.
- Requester 1 reads address 3 with bus_ack 3 cycles after the strobe and bus_rdata=0x3E -> bus_read_enable high exactly 1 cycle; resp_valid[1] with resp_data=0x3E, resp_error=0.
- Both requesters assert continuously from reset (rr_ptr=0) -> grants alternate 0,1,0,1; each transaction takes 3 cycles with an immediate ack; no starvation.
- timeout_cycles=4 with bus_ack never asserted -> resp_valid with resp_error=1 and resp_data=0 after 4 WAIT cycles; arbiter returns to IDLE and serves the next request.
- reset asserted during WAIT of a read -> no resp_valid; all outputs 0 after the edge; rr_ptr=0; a fresh request is served normally.
- Requester drops req_valid in the ISSUE cycle -> transaction still completes and resp_valid is delivered to that requester.

Source files
------------

// File: rtl/buff_uart_bus_arbiter_if.sv
// Requester and register-bus signals of the buffered UART bus arbiter.
// The arbiter connects through the slave modport, the environment through master.
interface buff_uart_bus_arbiter_if #(
    parameter int requesters    = 2,
    parameter int width         = 8,
    parameter int address_width = 8
);
    logic [requesters-1:0]               req_valid;
    logic [requesters-1:0]               req_write;
    logic [requesters*address_width-1:0] req_address;
    logic [requesters*width-1:0]         req_data;
    logic [requesters-1:0]               req_accept;
    logic [requesters-1:0]               resp_valid;
    logic [width-1:0]                    resp_data;
    logic                                resp_error;
    logic [address_width-1:0]            bus_address;
    logic                                bus_read_enable;
    logic                                bus_write_enable;
    logic [width-1:0]                    bus_wdata;
    logic [width-1:0]                    bus_rdata;
    logic                                bus_ack;
    logic                                busy;

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        input  bus_rdata, bus_ack,
        output req_accept, resp_valid, resp_data, resp_error,
        output bus_address, bus_read_enable, bus_write_enable,
        output bus_wdata, busy
    );

    modport master (
        output req_valid, req_write, req_address, req_data,
        output bus_rdata, bus_ack,
        input  req_accept, resp_valid, resp_data, resp_error,
        input  bus_address, bus_read_enable, bus_write_enable,
        input  bus_wdata, busy
    );
endinterface

// File: rtl/buff_uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART register bus between requesters.
// One transaction at a time: grant, strobe, wait for ack or timeout, respond.
module buff_uart_bus_arbiter #(
    parameter int requesters     = 2,
    parameter int width          = 8,
    parameter int address_width  = 8,
    parameter int timeout_cycles = 256
) (
    input logic                    clock,
    input logic                    reset,
    buff_uart_bus_arbiter_if.slave arb
);
    localparam int PW = (requesters > 1) ? $clog2(requesters) : 1;
    localparam int SW = PW + 1;
    localparam int CW = $clog2(timeout_cycles);
    localparam logic [SW-1:0] REQ_N = SW'(requesters);
    localparam logic [CW-1:0] LAST_WAIT = CW'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            owner;
    logic [CW-1:0]            counter;
    logic                     is_write;

    logic [2*requesters-1:0]  doubled;
    logic [requesters-1:0]    rotated;
    logic [PW-1:0]            offset;
    logic [SW-1:0]            sum;
    logic [PW-1:0]            grant_idx;
    logic                     grant_found;
    logic [requesters-1:0]    grant_onehot;
    logic [requesters-1:0]    owner_onehot;
    logic [address_width-1:0] addr_arr [requesters];
    logic [width-1:0]         data_arr [requesters];

    // Unpack the per-requester slices and build one-hot owner/grant vectors.
    always_comb begin
        addr_arr     = '{default: '0};
        data_arr     = '{default: '0};
        grant_onehot = '0;
        owner_onehot = '0;
        for (int i = 0; i < requesters; i++) begin
            addr_arr[i]     = arb.req_address[i*address_width +: address_width];
            data_arr[i]     = arb.req_data[i*width +: width];
            grant_onehot[i] = grant_found && (grant_idx == PW'(i));
            owner_onehot[i] = (owner == PW'(i));
        end
    end

    // Rotate requests so rr_ptr sits at bit 0, take the first set bit, then undo the rotation.
    always_comb begin
        doubled     = {arb.req_valid, arb.req_valid};
        rotated     = requesters'(doubled >> rr_ptr);
        grant_found = 1'b0;
        offset      = '0;
        for (int k = 0; k < requesters; k++) begin
            if (!grant_found && rotated[k]) begin
                grant_found = 1'b1;
                offset      = PW'(k);
            end
        end
        sum       = {1'b0, rr_ptr} + {1'b0, offset};
        grant_idx = (sum >= REQ_N) ? PW'(sum - REQ_N) : PW'(sum);
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            owner                <= '0;
            counter              <= '0;
            is_write             <= 1'b0;
            arb.req_accept       <= '0;
            arb.resp_valid       <= '0;
            arb.resp_data        <= '0;
            arb.resp_error       <= 1'b0;
            arb.bus_address      <= '0;
            arb.bus_read_enable  <= 1'b0;
            arb.bus_write_enable <= 1'b0;
            arb.bus_wdata        <= '0;
            arb.busy             <= 1'b0;
        end else begin
            arb.req_accept       <= '0;
            arb.resp_valid       <= '0;
            arb.bus_read_enable  <= 1'b0;
            arb.bus_write_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner                <= grant_idx;
                        is_write             <= arb.req_write[grant_idx];
                        arb.bus_address      <= addr_arr[grant_idx];
                        arb.bus_wdata        <= data_arr[grant_idx];
                        arb.req_accept       <= grant_onehot;
                        arb.bus_write_enable <= arb.req_write[grant_idx];
                        arb.bus_read_enable  <= !arb.req_write[grant_idx];
                        arb.busy             <= 1'b1;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    counter <= '0;
                    if (arb.bus_ack) begin
                        arb.resp_valid <= owner_onehot;
                        arb.resp_data  <= is_write ? '0 : arb.bus_rdata;
                        arb.resp_error <= 1'b0;
                        state          <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (arb.bus_ack) begin
                        arb.resp_valid <= owner_onehot;
                        arb.resp_data  <= is_write ? '0 : arb.bus_rdata;
                        arb.resp_error <= 1'b0;
                        state          <= RESP;
                    end else if (counter == LAST_WAIT) begin
                        arb.resp_valid <= owner_onehot;
                        arb.resp_data  <= '0;
                        arb.resp_error <= 1'b1;
                        state          <= RESP;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr   <= (owner == PW'(requesters - 1)) ? '0 : owner + 1'b1;
                    arb.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buff_uart_bus_arbiter.sv
// Bench for buff_uart_bus_arbiter: directed scenarios then random traffic,
// checked against a transaction-level round-robin model.
module tb_buff_uart_bus_arbiter;
    localparam int R  = 2;
    localparam int W  = 8;
    localparam int AW = 8;
    localparam int T  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    buff_uart_bus_arbiter_if #(.requesters(R), .width(W), .address_width(AW)) ifc ();

    buff_uart_bus_arbiter #(
        .requesters(R), .width(W), .address_width(AW), .timeout_cycles(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .arb(ifc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic          pend   [R];
    logic          p_wr   [R];
    logic [AW-1:0] p_addr [R];
    logic [W-1:0]  p_data [R];
    int            model_rr;
    logic [W-1:0]  last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive;
        for (int i = 0; i < R; i++) begin
            ifc.req_valid[i]               = pend[i];
            ifc.req_write[i]               = p_wr[i];
            ifc.req_address[i*AW +: AW]    = p_addr[i];
            ifc.req_data[i*W +: W]         = p_data[i];
        end
    endtask

    task automatic post(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] dt);
        pend[i]   = 1'b1;
        p_wr[i]   = w;
        p_addr[i] = a;
        p_data[i] = dt;
    endtask

    function automatic int pick();
        for (int k = 0; k < R; k++) begin
            if (pend[(model_rr + k) % R]) return (model_rr + k) % R;
        end
        return 0;
    endfunction

    task automatic clear_reqs;
        for (int i = 0; i < R; i++) pend[i] = 1'b0;
        drive();
    endtask

    // One full transaction. Starts in IDLE or RESP, ends in the RESP cycle.
    // d = cycle of ack counted from ISSUE (0 = zero-wait); d > T means never.
    task automatic txn(input int d, input logic [W-1:0] rd, output int got_owner, output int issue_cyc);
        int            own;
        int            n;
        int            c;
        int            exp_c;
        logic          ew;
        logic          exp_err;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        logic [W-1:0]  exp_data;
        logic [R-1:0]  oh;
        own = pick();
        ew  = p_wr[own];
        ea  = p_addr[own];
        ed  = p_data[own];
        oh  = '0;
        oh[own] = 1'b1;
        drive();
        n = 0;
        do begin
            ifc.bus_ack   = 1'($urandom_range(0, 1));
            ifc.bus_rdata = W'($urandom);
            tick();
            n++;
            if (ifc.req_accept == '0) begin
                check("idle_busy", ifc.busy, 0);
                check("idle_hold_data", ifc.resp_data, last_data);
            end
        end while (ifc.req_accept == '0 && n < 10);
        check("grant_seen", ifc.req_accept != '0, 1);
        got_owner = -1;
        for (int i = 0; i < R; i++) if (ifc.req_accept[i]) got_owner = i;
        issue_cyc = cyc;
        check("issue_accept", ifc.req_accept, oh);
        check("issue_addr", ifc.bus_address, ea);
        check("issue_wdata", ifc.bus_wdata, ed);
        check("issue_we", ifc.bus_write_enable, ew);
        check("issue_re", ifc.bus_read_enable, !ew);
        check("issue_busy", ifc.busy, 1);
        check("issue_no_resp", ifc.resp_valid, 0);
        pend[own] = 1'b0;
        drive();
        exp_err  = (d > T);
        exp_c    = exp_err ? T + 1 : d + 1;
        exp_data = (ew || exp_err) ? '0 : rd;
        c = 0;
        while (ifc.resp_valid == '0 && c < T + 4) begin
            if (c > 0) begin
                check("wait_strobes", {ifc.bus_read_enable, ifc.bus_write_enable}, 0);
                check("wait_addr_hold", ifc.bus_address, ea);
                check("wait_busy", ifc.busy, 1);
            end
            ifc.bus_ack   = (c == d);
            ifc.bus_rdata = (c == d) ? rd : W'($urandom);
            tick();
            c++;
        end
        check("resp_cycle", c, exp_c);
        check("resp_valid", ifc.resp_valid, oh);
        check("resp_data", ifc.resp_data, exp_data);
        check("resp_error", ifc.resp_error, exp_err);
        check("resp_strobes", {ifc.bus_read_enable, ifc.bus_write_enable}, 0);
        last_data     = exp_data;
        model_rr      = (own + 1) % R;
        ifc.bus_ack   = 1'($urandom_range(0, 1));
        ifc.bus_rdata = W'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_accept"}, ifc.req_accept, 0);
        check({tag, "_resp_valid"}, ifc.resp_valid, 0);
        check({tag, "_resp_data"}, ifc.resp_data, 0);
        check({tag, "_resp_error"}, ifc.resp_error, 0);
        check({tag, "_bus_address"}, ifc.bus_address, 0);
        check({tag, "_read_en"}, ifc.bus_read_enable, 0);
        check({tag, "_write_en"}, ifc.bus_write_enable, 0);
        check({tag, "_wdata"}, ifc.bus_wdata, 0);
        check({tag, "_busy"}, ifc.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o;
        int ic;
        int prev_ic;
        int n;
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = '0;
        for (int i = 0; i < R; i++) begin
            pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
        end
        drive();
        model_rr  = 0;
        last_data = '0;
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Zero-wait write from requester 0.
        post(0, 1'b1, 8'd4, 8'h0A);
        txn(0, 8'h00, o, ic);
        check("t1_owner", o, 0);

        // Requester 1 reads address 3 with ack three cycles after the strobe.
        post(1, 1'b0, 8'd3, 8'h00);
        txn(3, 8'h3E, o, ic);
        check("t2_owner", o, 1);

        // Both requesting continuously from reset: 0,1,0,1 every 3 cycles.
        reset = 1'b1;
        clear_reqs();
        tick();
        reset = 1'b0;
        model_rr  = 0;
        last_data = '0;
        post(0, 1'b0, 8'd3, 8'h00);
        post(1, 1'b1, 8'd4, 8'h55);
        prev_ic = 0;
        for (int k = 0; k < 4; k++) begin
            txn(0, W'($urandom), o, ic);
            check("rr_owner", o, k % 2);
            if (k > 0) check("rr_spacing", ic - prev_ic, 3);
            prev_ic = ic;
            post(o < 0 ? 0 : o, 1'(k), AW'(k + 3), W'(k));
        end

        // Timeout: no ack at all, then the next request is still served.
        txn(T + 3, 8'hFF, o, ic);
        txn(0, 8'h77, o, ic);

        // Reset during WAIT of a read aborts it.
        clear_reqs();
        post(1, 1'b0, 8'd3, 8'h00);
        drive();
        ifc.bus_ack = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifc.req_accept == '0 && n < 10);
        check("abort_accept", ifc.req_accept, 2'b10);
        pend[1] = 1'b0;
        drive();
        tick();
        tick();
        check("abort_in_wait", ifc.busy, 1);
        reset = 1'b1;
        tick();
        check_all_zero("abort");
        reset = 1'b0;
        model_rr  = 0;
        last_data = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_resp", ifc.resp_valid, 0);
            check("abort_idle", ifc.busy, 0);
        end
        post(0, 1'b1, 8'd4, 8'h21);
        post(1, 1'b1, 8'd4, 8'h12);
        txn(1, 8'h00, o, ic);
        check("abort_rr_zero", o, 0);
        txn(2, 8'h00, o, ic);
        check("abort_next", o, 1);

        // Requester drops req_valid in ISSUE; response still reaches it.
        post(1, 1'b0, 8'd3, 8'h00);
        txn(2, 8'hC3, o, ic);
        check("drop_owner", o, 1);

        // Random traffic against the model.
        for (int it = 0; it < 40; it++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < R; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    post(i, 1'($urandom), AW'($urandom), W'($urandom));
                if (pend[i]) any = 1'b1;
            end
            if (!any) post($urandom_range(0, R - 1), 1'($urandom), AW'($urandom), W'($urandom));
            txn($urandom_range(0, T + 2), W'($urandom), o, ic);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
